// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Purpose  : Receives a UART program image (SYNC, COUNT, N x 16-bit words,
//            CHK), writes each word to instruction memory and releases the
//            core only after a checksum-verified image has been loaded.
// Revision : 1.0 - initial release
// ============================================================================
module program_loader #(
   parameter int         CLKS_PER_BIT = 104,
   parameter int         ADDR_WIDTH   = 8,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_rx,
   output logic                  o_we,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic [15:0]           o_data,
   output logic                  o_core_run,
   output logic                  o_error
);

   localparam int                   c_CNT_W   = $clog2(CLKS_PER_BIT);
   localparam logic [c_CNT_W-1:0]   c_FULL_M1 = c_CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [c_CNT_W-1:0]   c_HALF_M1 = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [c_CNT_W-1:0]   c_CNT_ONE = 1;
   localparam logic [ADDR_WIDTH-1:0] c_IDX_ONE = 1;
   // 2^ADDR_WIDTH expressed wide enough to compare against any 8-bit COUNT
   localparam logic [ADDR_WIDTH+7:0] c_MAX_WORDS = {{7{1'b0}}, 1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   typedef enum logic [2:0] {
      F_WAIT_SYNC = 3'd0,
      F_GET_COUNT = 3'd1,
      F_GET_HI    = 3'd2,
      F_GET_LO    = 3'd3,
      F_GET_CHK   = 3'd4,
      F_RUN       = 3'd5,
      F_ERROR     = 3'd6
   } f_state_t;

   // ---------------- UART receiver ----------------
   logic               r_rx_meta, r_rx_sync, r_rx_prev;
   rx_state_t          r_rx_state, w_rx_nxt;
   logic [c_CNT_W-1:0] r_clk_cnt;
   logic [2:0]         r_bit_idx;
   logic [7:0]         r_rx_byte;
   logic               r_rx_valid, r_rx_ferr;
   logic               w_cnt_done;

   // The start bit is re-checked half a bit in; every later sample is a full bit apart
   assign w_cnt_done = (r_rx_state == RX_START) ? (r_clk_cnt == c_HALF_M1)
                                                : (r_clk_cnt == c_FULL_M1);

   // Two-flop synchronizer plus previous value for falling-edge detection
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= i_rx;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   // RX state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_rx_state <= RX_IDLE;
      else          r_rx_state <= w_rx_nxt;
   end

   // RX next-state: a start bit that reads high at mid-bit is a glitch
   always_comb begin
      w_rx_nxt = r_rx_state;
      case (r_rx_state)
         RX_IDLE:  if (r_rx_prev && !r_rx_sync) w_rx_nxt = RX_START;
         RX_START: if (w_cnt_done) w_rx_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_cnt_done && (r_bit_idx == 3'd7)) w_rx_nxt = RX_STOP;
         RX_STOP:  if (w_cnt_done) w_rx_nxt = RX_IDLE;
         default:  w_rx_nxt = RX_IDLE;
      endcase
   end

   // RX datapath: bit timer, LSB-first shift register, valid/ferr pulses
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_clk_cnt  <= '0;
         r_bit_idx  <= '0;
         r_rx_byte  <= '0;
         r_rx_valid <= 1'b0;
         r_rx_ferr  <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         r_rx_ferr  <= 1'b0;
         if ((r_rx_state == RX_IDLE) || w_cnt_done) r_clk_cnt <= '0;
         else                                       r_clk_cnt <= r_clk_cnt + c_CNT_ONE;
         if (r_rx_state == RX_IDLE) begin
            r_bit_idx <= '0;
         end else if ((r_rx_state == RX_DATA) && w_cnt_done) begin
            r_bit_idx <= r_bit_idx + 3'd1;
            r_rx_byte <= {r_rx_sync, r_rx_byte[7:1]};
         end
         if ((r_rx_state == RX_STOP) && w_cnt_done) begin
            r_rx_valid <= r_rx_sync;
            r_rx_ferr  <= ~r_rx_sync;
         end
      end
   end

   // ---------------- Frame parser ----------------
   f_state_t                r_f_state, w_f_nxt;
   logic                    w_we_nxt;
   logic                    r_we;
   logic [ADDR_WIDTH-1:0]   r_addr, r_idx, r_last_idx, w_last_idx;
   logic [15:0]             r_data;
   logic [7:0]              r_hi, r_sum;
   logic [ADDR_WIDTH+7:0]   w_count_ext;
   logic                    w_count_ovf, w_sync_hit;

   assign w_sync_hit  = r_rx_valid && (r_rx_byte == SYNC_BYTE);
   assign w_count_ext = {{ADDR_WIDTH{1'b0}}, r_rx_byte};
   assign w_count_ovf = (w_count_ext > c_MAX_WORDS);
   // COUNT = 0 encodes a full 2^ADDR_WIDTH image, so its last index is all ones
   assign w_last_idx  = (r_rx_byte == 8'h00) ? {ADDR_WIDTH{1'b1}}
                                             : ADDR_WIDTH'(r_rx_byte - 8'd1);

   // Frame state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_f_state <= F_WAIT_SYNC;
      else          r_f_state <= w_f_nxt;
   end

   // Frame next-state and write strobe decode
   always_comb begin
      w_f_nxt  = r_f_state;
      w_we_nxt = 1'b0;
      case (r_f_state)
         F_WAIT_SYNC, F_ERROR: begin
            if (w_sync_hit) w_f_nxt = F_GET_COUNT;
         end
         F_GET_COUNT: begin
            if (r_rx_ferr)       w_f_nxt = F_ERROR;
            else if (r_rx_valid) w_f_nxt = w_count_ovf ? F_ERROR : F_GET_HI;
         end
         F_GET_HI: begin
            if (r_rx_ferr)       w_f_nxt = F_ERROR;
            else if (r_rx_valid) w_f_nxt = F_GET_LO;
         end
         F_GET_LO: begin
            if (r_rx_ferr) begin
               w_f_nxt = F_ERROR;
            end else if (r_rx_valid) begin
               w_we_nxt = 1'b1;
               w_f_nxt  = (r_idx == r_last_idx) ? F_GET_CHK : F_GET_HI;
            end
         end
         F_GET_CHK: begin
            if (r_rx_ferr)       w_f_nxt = F_ERROR;
            else if (r_rx_valid) w_f_nxt = (r_rx_byte == r_sum) ? F_RUN : F_ERROR;
         end
         F_RUN:   w_f_nxt = F_RUN;
         default: w_f_nxt = F_WAIT_SYNC;
      endcase
   end

   // Frame datapath: word assembly, running checksum, registered write port
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
         r_idx      <= '0;
         r_last_idx <= '0;
         r_hi       <= '0;
         r_sum      <= '0;
      end else begin
         r_we <= w_we_nxt;
         if (r_rx_valid) begin
            case (r_f_state)
               F_WAIT_SYNC, F_ERROR: begin
                  if (w_sync_hit) begin
                     r_sum <= '0;
                     r_idx <= '0;
                  end
               end
               F_GET_COUNT: r_last_idx <= w_last_idx;
               F_GET_HI: begin
                  r_hi  <= r_rx_byte;
                  r_sum <= r_sum + r_rx_byte;
               end
               F_GET_LO: begin
                  r_data <= {r_hi, r_rx_byte};
                  r_addr <= r_idx;
                  r_idx  <= r_idx + c_IDX_ONE;
                  r_sum  <= r_sum + r_rx_byte;
               end
               default: ;
            endcase
         end
      end
   end

   assign o_we       = r_we;
   assign o_addr     = r_addr;
   assign o_data     = r_data;
   assign o_core_run = (r_f_state == F_RUN);
   assign o_error    = (r_f_state == F_ERROR);

endmodule
`default_nettype wire
